sccb_master: RTL and testbench

- Parametrised SCCB (camera serial control bus) master that performs single-register writes and reads to a camera sensor.
- Successor to the fixed 8-bit-address camera register writer. Adds a selectable 1- or 2-byte register address, a read transaction and a programmable bus rate.
- Sits between the UART command decoder / init ROM sequencer and the xopCAM_SIO_C / xbpCAM_SIO_D pins.
- The top level builds the tri-state: xbpCAM_SIO_D = opSIO_D_OE ? 1'b0 : 1'bz.

---
 rtl/sccb_master.sv | 227 ++++++++++++++++++++++
 tb/tb_sccb_master.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// SCCB master: single-register write/read with 1- or 2-byte address.
// Optional ACK checking is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_master #(
  parameter int CLK_DIV    = 125,
  parameter int ADDR_BYTES = 1
) (
  input  logic                    xipMCLK,
  input  logic                    xipRESET,
  input  logic                    ipSTART,
  input  logic                    ipRW,
  input  logic [6:0]              ipID,
  input  logic [8*ADDR_BYTES-1:0] ipADDR,
  input  logic [7:0]              ipWDATA,
  output logic [7:0]              opRDATA,
  output logic                    opBUSY,
  output logic                    opDONE,
  output logic                    opNACK,
  output logic                    opSIO_C,
  output logic                    opSIO_D_OE,
  input  logic                    ipSIO_D
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_BIT    = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [11:0] QMAX  = 12'(CLK_DIV - 1);
  localparam logic [1:0]  WLAST = 2'(ADDR_BYTES + 1);
  localparam logic [1:0]  RLAST = 2'(ADDR_BYTES);

  logic [2:0]  r_state;
  logic [11:0] r_qcnt;
  logic [1:0]  r_q;
  logic [3:0]  r_bit;
  logic [1:0]  r_byte;
  logic        r_phb;
  logic        r_rw;
  logic [6:0]  r_id;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rsh;
  logic [7:0]  r_rdata;
  logic        r_nack;
  logic        r_done;
  logic        r_busy;
  logic        r_sioc;
  logic        r_oe;

  logic        w_tick;
  logic [7:0]  w_byte;
  logic        w_bitval;
  logic        w_rdbyte;
  logic        w_last;
  logic        w_sioc;
  logic        w_oe;

  assign w_tick   = (r_qcnt == QMAX);
  assign w_rdbyte = r_phb && (r_byte == 2'd1);
  assign w_last   = r_phb ? (r_byte == 2'd1)
                  : (r_byte == (r_rw ? RLAST : WLAST));
  assign w_bitval = r_bit[3] ? 1'b1
                  : w_byte[3'd7 - r_bit[2:0]];

  // Select the byte currently being shifted out
  always_comb begin
    w_byte = r_wdata;
    if (r_byte == 2'd0)
      w_byte = {r_id, r_phb};
    else if (r_phb)
      w_byte = 8'hFF;
    else if (r_byte == 2'd1)
      w_byte = (ADDR_BYTES == 2) ? r_addr[15:8]
                                 : r_addr[7:0];
    else if (r_byte == 2'd2 && ADDR_BYTES == 2)
      w_byte = r_addr[7:0];
  end

  // Decode bus levels from the phase and quarter
  always_comb begin
    w_sioc = 1'b1;
    w_oe   = 1'b0;
    unique case (r_state)
      S_START: begin
        w_sioc = (r_q == 2'd0);
        w_oe   = 1'b1;
      end
      S_BIT: begin
        w_sioc = (r_q == 2'd1) || (r_q == 2'd2);
        w_oe   = ~w_bitval;
      end
      S_STOP: begin
        w_sioc = (r_q != 2'd0);
        w_oe   = (r_q < 2'd2);
      end
      default: begin
        w_sioc = 1'b1;
        w_oe   = 1'b0;
      end
    endcase
  end

  // Transaction FSM, quarter timer and registered bus pins
  always_ff @(posedge xipMCLK) begin
    if (xipRESET) begin
      r_state <= S_IDLE;
      r_qcnt  <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_phb   <= 1'b0;
      r_rw    <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rsh   <= '0;
      r_rdata <= '0;
      r_nack  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_sioc  <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_sioc <= w_sioc;
      r_oe   <= w_oe;
      if (r_state == S_IDLE || r_state == S_FINISH || w_tick)
        r_qcnt <= '0;
      else
        r_qcnt <= r_qcnt + 12'd1;
      unique case (r_state)
        S_IDLE: begin
          if (ipSTART) begin
            r_rw    <= ipRW;
            r_id    <= ipID;
            r_addr  <= 16'(ipADDR);
            r_wdata <= ipWDATA;
            r_state <= S_START;
            r_q     <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_phb   <= 1'b0;
            r_busy  <= 1'b1;
            r_nack  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_q == 2'd1) begin
              r_state <= S_BIT;
              r_q     <= '0;
              r_bit   <= '0;
              r_byte  <= '0;
            end else begin
              r_q <= r_q + 2'd1;
            end
          end
        end
        S_BIT: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd2 && !r_bit[3] && w_rdbyte)
              r_rsh <= {r_rsh[6:0], ipSIO_D};
`ifdef SCCB_ACK_CHECK_EN
            if (r_q == 2'd2 && r_bit[3] && !w_rdbyte && ipSIO_D)
              r_nack <= 1'b1;
`endif
            if (r_q == 2'd3) begin
              if (!r_bit[3]) begin
                r_bit <= r_bit + 4'd1;
              end else begin
                r_bit <= '0;
                if (w_last || r_nack)
                  r_state <= S_STOP;
                else
                  r_byte <= r_byte + 2'd1;
              end
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd3) begin
              if (r_rw && !r_phb && !r_nack) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                if (r_phb && !r_nack)
                  r_rdata <= r_rsh;
              end
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            if (r_q == 2'd3) begin
              r_state <= S_START;
              r_phb   <= 1'b1;
              r_byte  <= '0;
              r_bit   <= '0;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign opRDATA    = r_rdata;
  assign opBUSY     = r_busy;
  assign opDONE     = r_done;
  assign opSIO_C    = r_sioc;
  assign opSIO_D_OE = r_oe;
`ifdef SCCB_ACK_CHECK_EN
  assign opNACK     = r_nack;
`else
  assign opNACK     = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: a 1-byte-address and a 2-byte-address master,
// a bus monitor, an open-drain slave model and a token scoreboard.
`timescale 1ns/1ps
module tb_sccb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic        rw = 1'b0;
  logic [6:0]  id = '0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata0, rdata1;
  logic [1:0]  busy, done, nack, sioc, oe, sdi;

  logic        sel = 1'b0;
  logic        ack_en = 1'b1;
  logic [7:0]  rd_val = 8'h00;
  logic        sl_pull = 1'b0;

  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];
  int          cmp_n = 0;
  int          err_n = 0;
  time         acc_t = 0;

  logic        pc = 1'b1, pd = 1'b1;
  int          bc = 0, bytec = 0, cfall = 0;
  logic        rdf = 1'b0;
  logic [7:0]  sh = '0;

  always #5 clk = ~clk;

  assign sdi = ~oe & ~({sel, ~sel} & {2{sl_pull}});

  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(1)) u1 (
    .xipMCLK(clk), .xipRESET(rst), .ipSTART(start[0]),
    .ipRW(rw), .ipID(id), .ipADDR(addr[7:0]),
    .ipWDATA(wdata), .opRDATA(rdata0), .opBUSY(busy[0]),
    .opDONE(done[0]), .opNACK(nack[0]), .opSIO_C(sioc[0]),
    .opSIO_D_OE(oe[0]), .ipSIO_D(sdi[0]));

  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(2)) u2 (
    .xipMCLK(clk), .xipRESET(rst), .ipSTART(start[1]),
    .ipRW(rw), .ipID(id), .ipADDR(addr),
    .ipWDATA(wdata), .opRDATA(rdata1), .opBUSY(busy[1]),
    .opDONE(done[1]), .opNACK(nack[1]), .opSIO_C(sioc[1]),
    .opSIO_D_OE(oe[1]), .ipSIO_D(sdi[1]));

  // Bus monitor and slave: decodes START/STOP/bytes, drives ACK and read data
  always @(negedge clk) begin
    logic c, d;
    c = sioc[sel];
    d = sdi[sel];
    if (rst) begin
      bc = 0; bytec = 0; rdf = 1'b0; sl_pull = 1'b0;
    end else if (c && pc && pd && !d) begin
      obs_q.push_back(10'h100);
      bc = 0; bytec = 0; rdf = 1'b0;
    end else if (c && pc && !pd && d) begin
      obs_q.push_back(10'h200);
    end else if (c && !pc) begin
      if (bc < 8) begin
        sh = {sh[6:0], d};
        bc++;
      end else begin
        obs_q.push_back({2'b00, sh});
        if (bytec == 0) rdf = sh[0];
        bytec++;
        bc = 0;
      end
    end else if (!c && pc) begin
      cfall++;
      sl_pull = (bc == 8 && !(rdf && bytec == 1) && ack_en)
             || (rdf && bytec == 1 && bc < 8 && !rd_val[3'(7 - bc)]);
    end
    pc = c;
    pd = d;
  end

  task automatic push_w(input logic [6:0] i, input logic [7:0] a,
                        input logic [7:0] w);
    exp_q.push_back(10'h100);
    exp_q.push_back({2'b00, i, 1'b0});
    exp_q.push_back({2'b00, a});
    exp_q.push_back({2'b00, w});
    exp_q.push_back(10'h200);
  endtask

  task automatic kick(input logic s, input logic r, input logic [6:0] i,
                      input logic [15:0] a, input logic [7:0] w);
    @(negedge clk);
    rw = r; id = i; addr = a; wdata = w;
    start[s] = 1'b1;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic wait_done(input logic s, input int maxc, output int lat);
    lat = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done[s]) begin
        lat = int'(($time - acc_t - 5) / 10);
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] o;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = {sioc[s], oe[s], busy[s], done[s], nack[s],
           (s == 0) ? rdata0 : rdata1};
      cmp_n++;
      if (o !== 13'b1_0000_0000_0000) begin
        err_n++;
        $display("FAIL reset dut%0d got %b want 1000000000000", s, o);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int lat, n;
    logic [9:0] e, o;
    sel = 1'b0;
    push_w(7'h21, 8'h12, 8'h80);
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    cmp_n++;
    if (busy[0] !== 1'b1) begin
      err_n++; $display("FAIL write_busy got %b want 1", busy[0]);
    end
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456) begin
      err_n++; $display("FAIL write_lat got %0d want 456", lat);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL write_tok%0d got %h want %h", k, o, e);
      end
    end
    cmp_n++;
    if (obs_q.size() != 0) begin
      err_n++; $display("FAIL write_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    @(negedge clk);
    cmp_n++;
    if ({done[0], busy[0], sioc[0], oe[0]} !== 4'b0010) begin
      err_n++;
      $display("FAIL write_idle got %b want 0010",
               {done[0], busy[0], sioc[0], oe[0]});
    end
  endtask

  task automatic test_read();
    int lat, n;
    logic [9:0] e, o;
    sel = 1'b1;
    rd_val = 8'h56;
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h078);
    exp_q.push_back(10'h030);
    exp_q.push_back(10'h00A);
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h079);
    exp_q.push_back(10'h056);
    exp_q.push_back(10'h200);
    kick(1'b1, 1'b1, 7'h3C, 16'h300A, 8'h00);
    wait_done(1'b1, 2000, lat);
    cmp_n++;
    if (lat != 784) begin
      err_n++; $display("FAIL read_lat got %0d want 784", lat);
    end
    cmp_n++;
    if (rdata1 !== 8'h56) begin
      err_n++; $display("FAIL read_data got %h want 56", rdata1);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL read_tok%0d got %h want %h", k, o, e);
      end
    end
    cmp_n++;
    if (obs_q.size() != 0) begin
      err_n++; $display("FAIL read_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
    repeat (4) @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_ignore_start();
    int lat, n, dn;
    logic [9:0] e, o;
    sel = 1'b0;
    push_w(7'h21, 8'h12, 8'h80);
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    repeat (100) @(negedge clk);
    rw = 1'b1; id = 7'h7F; addr = 16'h00FF; wdata = 8'h00;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456) begin
      err_n++; $display("FAIL ignore_lat got %0d want 456", lat);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL ignore_tok%0d got %h want %h", k, o, e);
      end
    end
    obs_q.delete();
    dn = 0;
    repeat (600) begin
      @(negedge clk);
      if (done[0] || busy[0]) dn++;
    end
    cmp_n++;
    if (dn != 0) begin
      err_n++; $display("FAIL ignore_extra_done got %0d want 0", dn);
    end
  endtask

  task automatic test_reset_mid();
    int lat, n;
    logic [9:0] e, o;
    sel = 1'b0;
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_n++;
    if ({sioc[0], oe[0], busy[0]} !== 3'b100) begin
      err_n++;
      $display("FAIL rstmid_bus got %b want 100",
               {sioc[0], oe[0], busy[0]});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    push_w(7'h30, 8'h5A, 8'hC3);
    kick(1'b0, 1'b0, 7'h30, 16'h005A, 8'hC3);
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456) begin
      err_n++; $display("FAIL rstmid_lat got %0d want 456", lat);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL rstmid_tok%0d got %h want %h", k, o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_nack();
    int lat, n, xl;
    logic xn;
    logic [9:0] e, o;
    sel = 1'b0;
    ack_en = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h042);
    exp_q.push_back(10'h200);
    xl = 168;
    xn = 1'b1;
`else
    push_w(7'h21, 8'h12, 8'h80);
    xl = 456;
    xn = 1'b0;
`endif
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != xl) begin
      err_n++; $display("FAIL nack_lat got %0d want %0d", lat, xl);
    end
    cmp_n++;
    if (nack[0] !== xn) begin
      err_n++; $display("FAIL nack_flag got %b want %b", nack[0], xn);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL nack_tok%0d got %h want %h", k, o, e);
      end
    end
    obs_q.delete();
    ack_en = 1'b1;
    push_w(7'h21, 8'h12, 8'h80);
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    cmp_n++;
    if (nack[0] !== 1'b0) begin
      err_n++; $display("FAIL nack_clear got %b want 0", nack[0]);
    end
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456 || nack[0] !== 1'b0) begin
      err_n++;
      $display("FAIL nack_next got lat %0d nack %b want 456 0",
               lat, nack[0]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int lat, n, cf0;
    logic [9:0] e, o;
    sel = 1'b0;
    push_w(7'h21, 8'h12, 8'h80);
    push_w(7'h21, 8'h34, 8'h56);
    kick(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80);
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456) begin
      err_n++; $display("FAIL b2b_lat1 got %0d want 456", lat);
    end
    cf0 = cfall;
    kick(1'b0, 1'b0, 7'h21, 16'h0034, 8'h56);
    cmp_n++;
    if (busy[0] !== 1'b1) begin
      err_n++; $display("FAIL b2b_accept got %b want 1", busy[0]);
    end
    repeat (2) @(negedge clk);
    cmp_n++;
    if (cfall != cf0 || sioc[0] !== 1'b1) begin
      err_n++;
      $display("FAIL b2b_glitch got falls %0d scl %b want 0 1",
               cfall - cf0, sioc[0]);
    end
    wait_done(1'b0, 1000, lat);
    cmp_n++;
    if (lat != 456) begin
      err_n++; $display("FAIL b2b_lat2 got %0d want 456", lat);
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      cmp_n++;
      if (o !== e) begin
        err_n++; $display("FAIL b2b_tok%0d got %h want %h", k, o, e);
      end
    end
    cmp_n++;
    if (obs_q.size() != 0) begin
      err_n++; $display("FAIL b2b_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_reset_mid();
    test_nack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
